// File: rtl/pixel_frame_sequencer.sv
// pixel_frame_sequencer
//
// Runs one image capture of the pixel array: erase, exposure, ADC conversion
// ramp, then a row-by-row readout in bus-sized chunks.  Readout is paced
// against the downstream buffer with a valid/ready handshake.
//
// Ports:
//   CLK             system clock, everything on the rising edge
//   RESET           synchronous active-high reset
//   START           frame request, only looked at in IDLE
//   EXPOSE_TIME     exposure length in cycles (0 behaves as 1), latched on START
//   BUF_READY       downstream buffer accepts the offered word this cycle
//   ERASE           pixel erase strobe
//   EXPOSE          pixel exposure enable
//   CONVERT         ADC ramp / convert enable
//   READ_EN         array readout enable, high for the whole readout
//   ROW_SEL         row currently offered
//   COL_SEL         chunk index within the row currently offered
//   WORD_VALID      ROW_SEL/COL_SEL word is offered to the buffer
//   FRAME_FINISHED  one-cycle pulse after the last word is taken
//   BUSY            high in every state except IDLE
//
// State table
//   state     | meaning
//   S_IDLE    | waiting for START
//   S_ERASE   | ERASE high for ERASE_CYCLES cycles
//   S_EXPOSE  | EXPOSE high for the latched exposure time
//   S_CONVERT | CONVERT high for 2**PIXEL_BITS cycles
//   S_READ    | offering words, advancing on each accepted transfer
//   S_DONE    | FRAME_FINISHED pulse, back to idle next cycle

module pixel_frame_sequencer #(
    parameter int ARRAY_HEIGHT = 128,
    parameter int ARRAY_WIDTH  = 128,
    parameter int BUS_WIDTH    = 4,
    parameter int PIXEL_BITS   = 8,
    parameter int ERASE_CYCLES = 5,
    parameter int EXPOSE_W     = 16,
    localparam int ROW_W         = $clog2(ARRAY_HEIGHT),
    localparam int WORDS_PER_ROW = ARRAY_WIDTH / BUS_WIDTH,
    localparam int COL_W         = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                START,
    input  logic [EXPOSE_W-1:0] EXPOSE_TIME,
    input  logic                BUF_READY,
    output logic                ERASE,
    output logic                EXPOSE,
    output logic                CONVERT,
    output logic                READ_EN,
    output logic [ROW_W-1:0]    ROW_SEL,
    output logic [COL_W-1:0]    COL_SEL,
    output logic                WORD_VALID,
    output logic                FRAME_FINISHED,
    output logic                BUSY
);

    // One shared down-counter times every fixed-length phase; it must hold
    // the largest load value of any of them.
    localparam int ERASE_W = $clog2(ERASE_CYCLES) + 1;
    localparam int TMR_W0  = (EXPOSE_W > PIXEL_BITS) ? EXPOSE_W : PIXEL_BITS;
    localparam int TMR_W   = (TMR_W0 > ERASE_W) ? TMR_W0 : ERASE_W;

    localparam logic [TMR_W-1:0] ERASE_LOAD = TMR_W'(ERASE_CYCLES - 1);
    localparam logic [TMR_W-1:0] CONV_LOAD  = TMR_W'((1 << PIXEL_BITS) - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ARRAY_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(WORDS_PER_ROW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_READ,
        S_DONE
    } state_t;

    state_t              state, state_nx;
    logic [TMR_W-1:0]    timer, timer_nx;
    logic [EXPOSE_W-1:0] expose_lat, expose_lat_nx;
    logic [ROW_W-1:0]    row_nx;
    logic [COL_W-1:0]    col_nx;
    logic                erase_nx, expose_nx, convert_nx, read_nx;
    logic                valid_nx, finished_nx, busy_nx;

    always_comb begin
        state_nx      = state;
        timer_nx      = timer;
        expose_lat_nx = expose_lat;
        row_nx        = ROW_SEL;
        col_nx        = COL_SEL;

        case (state)
            S_IDLE: begin
                if (START) begin
                    state_nx      = S_ERASE;
                    timer_nx      = ERASE_LOAD;
                    expose_lat_nx = (EXPOSE_TIME == '0) ? EXPOSE_W'(1) : EXPOSE_TIME;
                end
            end
            S_ERASE: begin
                if (timer == '0) begin
                    state_nx = S_EXPOSE;
                    // expose_lat is never 0 here, so the subtraction cannot wrap
                    timer_nx = TMR_W'(expose_lat - EXPOSE_W'(1));
                end else begin
                    timer_nx = timer - TMR_W'(1);
                end
            end
            S_EXPOSE: begin
                if (timer == '0) begin
                    state_nx = S_CONVERT;
                    timer_nx = CONV_LOAD;
                end else begin
                    timer_nx = timer - TMR_W'(1);
                end
            end
            S_CONVERT: begin
                if (timer == '0) begin
                    state_nx = S_READ;
                    row_nx   = '0;
                    col_nx   = '0;
                end else begin
                    timer_nx = timer - TMR_W'(1);
                end
            end
            S_READ: begin
                if (BUF_READY) begin
                    if (COL_SEL == COL_LAST) begin
                        col_nx = '0;
                        if (ROW_SEL == ROW_LAST) begin
                            state_nx = S_DONE;
                            row_nx   = '0;
                        end else begin
                            row_nx = ROW_SEL + ROW_W'(1);
                        end
                    end else begin
                        col_nx = COL_SEL + COL_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state.
        erase_nx    = (state_nx == S_ERASE);
        expose_nx   = (state_nx == S_EXPOSE);
        convert_nx  = (state_nx == S_CONVERT);
        read_nx     = (state_nx == S_READ);
        valid_nx    = (state_nx == S_READ);
        finished_nx = (state_nx == S_DONE);
        busy_nx     = (state_nx != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state          <= S_IDLE;
            timer          <= '0;
            expose_lat     <= '0;
            ROW_SEL        <= '0;
            COL_SEL        <= '0;
            ERASE          <= 1'b0;
            EXPOSE         <= 1'b0;
            CONVERT        <= 1'b0;
            READ_EN        <= 1'b0;
            WORD_VALID     <= 1'b0;
            FRAME_FINISHED <= 1'b0;
            BUSY           <= 1'b0;
        end else begin
            state          <= state_nx;
            timer          <= timer_nx;
            expose_lat     <= expose_lat_nx;
            ROW_SEL        <= row_nx;
            COL_SEL        <= col_nx;
            ERASE          <= erase_nx;
            EXPOSE         <= expose_nx;
            CONVERT        <= convert_nx;
            READ_EN        <= read_nx;
            WORD_VALID     <= valid_nx;
            FRAME_FINISHED <= finished_nx;
            BUSY           <= busy_nx;
        end
    end

endmodule
